// File: rtl/vscale_dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the size/alignment legality check.
package vscale_dmem_responder_pkg;

  localparam logic [2:0] DMEM_SIZE_B  = 3'd0;
  localparam logic [2:0] DMEM_SIZE_H  = 3'd1;
  localparam logic [2:0] DMEM_SIZE_W  = 3'd2;
  localparam logic [2:0] DMEM_SIZE_BU = 3'd4;
  localparam logic [2:0] DMEM_SIZE_HU = 3'd5;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Sizes outside the legal funct3 set are reported as misaligned too.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      DMEM_SIZE_B, DMEM_SIZE_BU: misaligned = 1'b0;
      DMEM_SIZE_H, DMEM_SIZE_HU: misaligned = off[0];
      DMEM_SIZE_W:               misaligned = (off != 2'b00);
      default:                   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/vscale_dmem_responder_sram.sv
// Word-addressed backing store with byte-enable write and synchronous read;
// a read concurrent with a write to the same word returns the old contents.
module vscale_dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder: accepts pipelined load/store requests, inserts wait
// states, flags bad accesses and returns lane-extracted, extended load data.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_e   state;
  logic [CW-1:0] cnt;
  logic          r_wen;
  logic [2:0]    r_size;
  logic [AW+1:0] r_addr;
  logic          r_err;

  logic          accept;
  logic          req_err;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   sram_q;

  logic          fwd_hit;
  logic [3:0]    fwd_be;
  logic [31:0]   fwd_data;

  logic [31:0]   word;
  logic [31:0]   ext;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign accept  = dmem_en && !dmem_wait;
  assign req_err = misaligned(dmem_size, dmem_addr[1:0]) ||
                   (32'(dmem_addr[31:2]) >= 32'(DEPTH_WORDS));

  assign wr_idx = r_addr[AW+1:2];
  assign rd_idx = accept ? dmem_addr[AW+1:2] : r_addr[AW+1:2];
  assign wr_en  = (state == ST_RESP) && r_wen && !r_err;

  // Replicating the store data puts it in every candidate lane; the byte
  // enables pick the ones actually written.
  always_comb begin
    wr_data = dmem_wdata;
    wr_be   = 4'hF;
    case (r_size[1:0])
      2'd0: begin
        wr_data = {4{dmem_wdata[7:0]}};
        wr_be   = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        wr_data = {2{dmem_wdata[15:0]}};
        wr_be   = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  vscale_dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_sram (
    .clk     (clk),
    .rd_addr (rd_idx),
    .rd_data (sram_q),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dmem_wait <= 1'b0;
      r_wen     <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_be    <= '0;
      fwd_data  <= '0;
    end else begin
      // The array returns pre-write data when a store lands on the edge the
      // read is issued, so remember the written lanes for the next cycle.
      fwd_hit  <= wr_en && (rd_idx == wr_idx);
      fwd_be   <= wr_be;
      fwd_data <= wr_data;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            r_wen  <= dmem_wen;
            r_size <= dmem_size;
            r_addr <= dmem_addr[AW+1:0];
            r_err  <= req_err;
            if (req_err || WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              dmem_wait <= 1'b0;
            end else begin
              state     <= ST_WAIT;
              cnt       <= CW'(WAIT_CYCLES - 1);
              dmem_wait <= 1'b1;
            end
          end else begin
            state     <= ST_IDLE;
            dmem_wait <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_RESP;
            dmem_wait <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          dmem_wait <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    word = sram_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd_hit && fwd_be[i]) word[8*i +: 8] = fwd_data[8*i +: 8];
    end
    byte_v = 8'(word >> {r_addr[1:0], 3'b000});
    half_v = 16'(word >> {r_addr[1], 4'b0000});
    ext    = '0;
    case (r_size)
      DMEM_SIZE_B:  ext = {{24{byte_v[7]}}, byte_v};
      DMEM_SIZE_H:  ext = {{16{half_v[15]}}, half_v};
      DMEM_SIZE_W:  ext = word;
      DMEM_SIZE_BU: ext = {24'd0, byte_v};
      DMEM_SIZE_HU: ext = {16'd0, half_v};
      default:      ext = '0;
    endcase
    dmem_rdata = (state == ST_RESP && !r_err && !r_wen) ? ext : '0;
  end

  assign dmem_badmem_e = (state == ST_RESP) && r_err;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: two instances (0 and 2 wait states) checked
// against a byte-addressed memory model with directed and random accesses.
module tb_vscale_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, en2, wen;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata2;
  logic        wait0, wait2, bad0, bad2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] mb [2][NBYTE];

  always #5 clk = ~clk;

  vscale_dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .dmem_en(en0), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata0),
    .dmem_wait(wait0), .dmem_badmem_e(bad0));

  vscale_dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .dmem_en(en2), .dmem_wen(wen), .dmem_size(size),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_rdata(rdata2),
    .dmem_wait(wait2), .dmem_badmem_e(bad2));

  function automatic int unsigned nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [2:0] sz, input logic [31:0] a);
    int unsigned n;
    n = nbytes(sz);
    if (n == 0) return 1'b1;
    if (a % n != 0) return 1'b1;
    return a >= NBYTE;
  endfunction

  function automatic logic [31:0] model_load(input bit d, input logic [2:0] sz, input logic [31:0] a);
    int unsigned n;
    logic [31:0] v;
    if (is_bad(sz, a)) return '0;
    n = nbytes(sz);
    v = '0;
    for (int unsigned k = 0; k < n; k++) v = v | (32'(mb[d][a + k]) << (8 * k));
    if (sz < 3'd4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input bit d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int unsigned k = 0; k < nbytes(sz); k++) mb[d][a + k] = wd[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d, input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    wen = w; size = sz; addr = a; wdata = wd;
    if (d) en2 = 1'b1; else en0 = 1'b1;
  endtask

  // Entered just after the accepting edge; returns at the negedge of RESP.
  task automatic resp_phase(input bit d, input bit bad, input bit is_load, input logic [31:0] exp, input string tag);
    int unsigned waits;
    bit done;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if ((d ? wait2 : wait0) === 1'b1) waits++; else done = 1'b1;
    end
    check({tag, "/timeout"}, 32'(done), 32'd1);
    check({tag, "/waits"}, waits, bad ? 0 : (d ? 2 : 0));
    check({tag, "/badmem"}, 32'(d ? bad2 : bad0), 32'(bad));
    if (is_load) check({tag, "/rdata"}, d ? rdata2 : rdata0, exp);
  endtask

  task automatic xact(input bit d, input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit bad;
    logic [31:0] exp;
    bad = is_bad(sz, a);
    exp = w ? '0 : model_load(d, sz, a);
    drive(d, w, sz, a, wd);
    @(posedge clk); #1;
    en0 = 1'b0; en2 = 1'b0;
    resp_phase(d, bad, !w, exp, tag);
    if (w && !bad) model_store(d, sz, a, wd);
    @(posedge clk); #1;
  endtask

  // Store immediately followed by a load accepted in the store's RESP cycle.
  task automatic b2b(input bit d, input logic [2:0] ssz, input logic [31:0] sa, input logic [31:0] wd,
                     input logic [2:0] lsz, input logic [31:0] la, input string tag);
    drive(d, 1'b1, ssz, sa, wd);
    @(posedge clk); #1;
    en0 = 1'b0; en2 = 1'b0;
    resp_phase(d, is_bad(ssz, sa), 1'b0, '0, {tag, "/st"});
    if (!is_bad(ssz, sa)) model_store(d, ssz, sa, wd);
    wen = 1'b0; size = lsz; addr = la;
    if (d) en2 = 1'b1; else en0 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0; en2 = 1'b0;
    resp_phase(d, is_bad(lsz, la), 1'b1, model_load(d, lsz, la), {tag, "/ld"});
    @(posedge clk); #1;
  endtask

  initial begin
    bit d, w;
    logic [2:0] sz, lsz;
    logic [31:0] a, la;
    int unsigned n, wi;

    reset = 1'b0; en0 = 1'b0; en2 = 1'b0; wen = 1'b0;
    size = '0; addr = '0; wdata = '0;
    #2;
    check("rst_wait0", 32'(wait0), 32'd0);
    check("rst_bad0", 32'(bad0), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_wait2", 32'(wait2), 32'd0);
    check("rst_bad2", 32'(bad2), 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < DEPTH; i++) xact(1'b0, 1'b1, 3'd2, i * 4, $urandom, "init0");
    for (int unsigned i = 0; i < DEPTH; i++) xact(1'b1, 1'b1, 3'd2, i * 4, $urandom, "init2");

    xact(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, "w2_sw");
    xact(1'b1, 1'b0, 3'd2, 32'h100, '0, "w2_lw");

    xact(1'b0, 1'b1, 3'd0, 32'h203, 32'h80, "sb");
    xact(1'b0, 1'b0, 3'd0, 32'h203, '0, "lb");
    xact(1'b0, 1'b0, 3'd4, 32'h203, '0, "lbu");
    xact(1'b0, 1'b1, 3'd1, 32'h202, 32'h1234, "sh");
    xact(1'b0, 1'b0, 3'd2, 32'h200, '0, "lw_sh");

    for (int unsigned k = 0; k < 2; k++) begin
      d = k[0];
      xact(d, 1'b0, 3'd2, 32'h102, '0, "lw_mis");
      xact(d, 1'b1, 3'd1, 32'h101, 32'hFFFF, "sh_mis");
      xact(d, 1'b0, 3'd2, 32'h100, '0, "lw_after_sh_mis");
      xact(d, 1'b0, 3'd3, 32'h100, '0, "size3");
      xact(d, 1'b0, 3'd2, NBYTE, '0, "oor");
    end

    b2b(1'b0, 3'd2, 32'h40, 32'h0000AAAA, 3'd2, 32'h40, "fwd0");
    b2b(1'b1, 3'd2, 32'h40, 32'h0000AAAA, 3'd2, 32'h40, "fwd2");

    // Reset during WAIT of a store must drop it.
    xact(1'b1, 1'b1, 3'd2, 32'h80, 32'h11112222, "pre_rst");
    drive(1'b1, 1'b1, 3'd2, 32'h80, 32'h55);
    @(posedge clk); #1;
    en2 = 1'b0;
    @(negedge clk);
    check("mid_wait", 32'(wait2), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_wait", 32'(wait2), 32'd0);
    check("mid_rst_bad", 32'(bad2), 32'd0);
    check("mid_rst_rdata", rdata2, 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b1, 1'b0, 3'd2, 32'h80, '0, "post_rst_lw");

    for (int i = 0; i < 40; i++) begin
      d  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      wi = $urandom_range(0, DEPTH - 1);
      n  = nbytes(sz);
      a  = wi * 4 + ($urandom_range(0, 3) / n) * n;
      case ($urandom_range(0, 4))
        0: lsz = 3'd0; 1: lsz = 3'd1; 2: lsz = 3'd2; 3: lsz = 3'd4; default: lsz = 3'd5;
      endcase
      n  = nbytes(lsz);
      la = wi * 4 + ($urandom_range(0, 3) / n) * n;
      b2b(d, sz, a, $urandom, lsz, la, "rand_b2b");
    end

    for (int i = 0; i < 150; i++) begin
      d = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (w) sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      else   sz = 3'($urandom_range(0, 7));
      a = $urandom_range(0, NBYTE + 127);
      n = nbytes(sz);
      if (n != 0 && $urandom_range(0, 3) != 0) a = a - (a % n);
      xact(d, w, sz, a, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
